// File: rtl/detector_secuencias_param.sv
// -----------------------------------------------------------------------------
// detector_secuencias_param
// Parametrised serial sequence detector. Bits are shifted in MSB-first
// (the first received bit lines up with PATTERN[N-1]). When the last N
// qualified bits equal the pattern, det strobes for one cycle and the
// saturating match counter advances.
//
// Optional build macro: DET_MASK_EN
//   Defined   -> adds mask_in[N-1:0] and a mask register. A mask bit of 1
//                compares that position; 0 makes it don't-care.
//   Undefined -> every pattern bit is compared.
// -----------------------------------------------------------------------------
module detector_secuencias_param #(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1011,
    parameter bit           OVERLAP = 1'b1,
    parameter int           CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din,
    input  logic                       en,
    input  logic                       load,
    input  logic [N-1:0]               pat_in,
`ifdef DET_MASK_EN
    input  logic [N-1:0]               mask_in,
`endif
    input  logic                       clr_cnt,
    output logic                       det,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [$clog2(N+1)-1:0]     fill
);

    localparam int               FW        = $clog2(N + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(N);
    localparam logic [FW-1:0]    FILL_ZERO = FW'(0);
    localparam logic [FW-1:0]    FILL_ONE  = FW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [N-1:0]     HIST_ZERO = {N{1'b0}};
    localparam logic [N-1:0]     MASK_ALL  = {N{1'b1}};

    // Masked equality: every position with a mask bit of 1 must agree.
    function automatic logic pattern_hit(
        input logic [N-1:0] hist_v,
        input logic [N-1:0] pat_v,
        input logic [N-1:0] mask_v
    );
        return (((hist_v ^ pat_v) & mask_v) == {N{1'b0}});
    endfunction

    // State registers
    logic [N-1:0]     hist_r;
    logic [FW-1:0]    fill_r;
    logic             det_r;
    logic [CNT_W-1:0] cnt_r;
    logic [N-1:0]     pat_r;
    logic [N-1:0]     mask_r;

    // Next-state signals
    logic [N-1:0]     hist_shift_s;
    logic [FW-1:0]    fill_inc_s;
    logic             match_s;
    logic [N-1:0]     hist_nxt_s;
    logic [FW-1:0]    fill_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [N-1:0]     pat_nxt_s;
    logic [N-1:0]     mask_nxt_s;

    // Candidate history and fill level if the current bit were accepted.
    always_comb begin
        hist_shift_s = {hist_r[N-2:0], din};
        if (fill_r == FILL_FULL) begin
            fill_inc_s = FILL_FULL;
        end else begin
            fill_inc_s = fill_r + FILL_ONE;
        end
    end

    // A match needs a qualified bit, a full window and the masked compare to hold.
    // load takes precedence over en, so a load cycle never matches.
    always_comb begin
        match_s = 1'b0;
        if (en && !load && (fill_inc_s == FILL_FULL) &&
            pattern_hit(hist_shift_s, pat_r, mask_r)) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
    end

    // History / fill update: load flushes, en shifts, otherwise hold.
    // Without overlap a match consumes the whole window.
    always_comb begin
        hist_nxt_s = hist_r;
        fill_nxt_s = fill_r;
        if (load) begin
            hist_nxt_s = HIST_ZERO;
            fill_nxt_s = FILL_ZERO;
        end else if (en) begin
            if (match_s && (OVERLAP == 1'b0)) begin
                hist_nxt_s = HIST_ZERO;
                fill_nxt_s = FILL_ZERO;
            end else begin
                hist_nxt_s = hist_shift_s;
                fill_nxt_s = fill_inc_s;
            end
        end else begin
            hist_nxt_s = hist_r;
            fill_nxt_s = fill_r;
        end
    end

    // Saturating match counter; a clear that coincides with a match keeps the match.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr_cnt) begin
            if (match_s) begin
                cnt_nxt_s = CNT_ONE;
            end else begin
                cnt_nxt_s = CNT_ZERO;
            end
        end else if (match_s && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Pattern and mask reload.
    always_comb begin
        pat_nxt_s  = pat_r;
        mask_nxt_s = mask_r;
        if (load) begin
            pat_nxt_s  = pat_in;
`ifdef DET_MASK_EN
            mask_nxt_s = mask_in;
`else
            mask_nxt_s = MASK_ALL;
`endif
        end else begin
            pat_nxt_s  = pat_r;
            mask_nxt_s = mask_r;
        end
    end

    // Register all state; synchronous reset restores the power-on pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_r <= HIST_ZERO;
            fill_r <= FILL_ZERO;
            det_r  <= 1'b0;
            cnt_r  <= CNT_ZERO;
            pat_r  <= PATTERN;
            mask_r <= MASK_ALL;
        end else begin
            hist_r <= hist_nxt_s;
            fill_r <= fill_nxt_s;
            det_r  <= match_s;
            cnt_r  <= cnt_nxt_s;
            pat_r  <= pat_nxt_s;
            mask_r <= mask_nxt_s;
        end
    end

    assign det       = det_r;
    assign match_cnt = cnt_r;
    assign fill      = fill_r;

endmodule

// File: tb/tb_detector_secuencias_param.sv
// -----------------------------------------------------------------------------
// Bench for detector_secuencias_param. Three instances share one stimulus
// stream: overlapping (CNT_W=8), non-overlapping (CNT_W=8) and overlapping
// with a 2-bit counter. A reference model pushes expected outputs into a
// scoreboard queue each cycle; they are popped after the clock edge.
// Honours DET_MASK_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_detector_secuencias_param;

    logic       clk = 1'b0;
    logic       rst, din, en, load, clr_cnt;
    logic [3:0] pat_in;
    logic [3:0] mask_in;

    logic       det_ov, det_nov, det_sat;
    logic [7:0] cnt_ov, cnt_nov;
    logic [1:0] cnt_sat;
    logic [2:0] fill_ov, fill_nov, fill_sat;

    always #5 clk = ~clk;

    detector_secuencias_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
        .clk(clk), .rst(rst), .din(din), .en(en), .load(load), .pat_in(pat_in),
`ifdef DET_MASK_EN
        .mask_in(mask_in),
`endif
        .clr_cnt(clr_cnt), .det(det_ov), .match_cnt(cnt_ov), .fill(fill_ov));

    detector_secuencias_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
        .clk(clk), .rst(rst), .din(din), .en(en), .load(load), .pat_in(pat_in),
`ifdef DET_MASK_EN
        .mask_in(mask_in),
`endif
        .clr_cnt(clr_cnt), .det(det_nov), .match_cnt(cnt_nov), .fill(fill_nov));

    detector_secuencias_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .din(din), .en(en), .load(load), .pat_in(pat_in),
`ifdef DET_MASK_EN
        .mask_in(mask_in),
`endif
        .clr_cnt(clr_cnt), .det(det_sat), .match_cnt(cnt_sat), .fill(fill_sat));

    typedef struct packed {
        logic       det;
        logic [7:0] cnt;
        logic [2:0] fill;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state, one slot per instance.
    logic [3:0]  pat_m  = 4'b1011;
    logic [3:0]  mask_m = 4'b1111;
    logic [31:0] hist_m [3];
    int          nseen_m[3];
    int          cnt_m  [3];
    int          cmax   [3] = '{255, 255, 3};
    bit          ov     [3] = '{1'b1, 1'b0, 1'b1};

`ifdef DET_MASK_EN
    localparam logic EXP_MASK_DET = 1'b1;
`else
    localparam logic EXP_MASK_DET = 1'b0;
`endif

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock and push expected outputs for each instance.
    task automatic model_push(input logic r, input logic l, input logic e, input logic d,
                              input logic c, input logic [3:0] p, input logic [3:0] m);
        for (int k = 0; k < 3; k++) begin
            logic hit;
            exp_t x;
            hit = 1'b0;
            if (r) begin
                nseen_m[k] = 0;
                hist_m[k]  = 32'd0;
                cnt_m[k]   = 0;
            end else begin
                if (l) begin
                    nseen_m[k] = 0;
                    hist_m[k]  = 32'd0;
                end else if (e) begin
                    hist_m[k]  = {hist_m[k][30:0], d};
                    nseen_m[k] = nseen_m[k] + 1;
                    if (nseen_m[k] >= 4) begin
                        hit = 1'b1;
                        for (int i = 0; i < 4; i++)
                            if (mask_m[i] && (hist_m[k][i] !== pat_m[i])) hit = 1'b0;
                    end
                    if (hit && !ov[k]) begin
                        nseen_m[k] = 0;
                        hist_m[k]  = 32'd0;
                    end
                end
                if (c) cnt_m[k] = hit ? 1 : 0;
                else if (hit && (cnt_m[k] < cmax[k])) cnt_m[k] = cnt_m[k] + 1;
            end
            x.det  = hit;
            x.cnt  = 8'(cnt_m[k]);
            x.fill = 3'((nseen_m[k] > 4) ? 4 : nseen_m[k]);
            sb.push_back(x);
        end
        if (r) begin
            pat_m  = 4'b1011;
            mask_m = 4'b1111;
        end else if (l) begin
            pat_m = p;
`ifdef DET_MASK_EN
            mask_m = m;
`else
            mask_m = 4'b1111;
`endif
        end
    endtask

    // Drive one cycle of stimulus, then compare all instances against the scoreboard.
    task automatic step(input logic r, input logic l, input logic e, input logic d,
                        input logic c, input logic [3:0] p, input logic [3:0] m);
        exp_t x;
        @(negedge clk);
        rst = r; load = l; en = e; din = d; clr_cnt = c; pat_in = p; mask_in = m;
        model_push(r, l, e, d, c, p, m);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check_val("ov_det",  {31'd0, det_ov}, {31'd0, x.det});
        check_val("ov_cnt",  {24'd0, cnt_ov}, {24'd0, x.cnt});
        check_val("ov_fill", {29'd0, fill_ov}, {29'd0, x.fill});
        x = sb.pop_front();
        check_val("nov_det",  {31'd0, det_nov}, {31'd0, x.det});
        check_val("nov_cnt",  {24'd0, cnt_nov}, {24'd0, x.cnt});
        check_val("nov_fill", {29'd0, fill_nov}, {29'd0, x.fill});
        x = sb.pop_front();
        check_val("sat_det",  {31'd0, det_sat}, {31'd0, x.det});
        check_val("sat_cnt",  {30'd0, cnt_sat}, {24'd0, x.cnt});
        check_val("sat_fill", {29'd0, fill_sat}, {29'd0, x.fill});
    endtask

    task automatic bit_in(input logic d);
        step(1'b0, 1'b0, 1'b1, d, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic do_rst();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] seq1;
        rst = 1'b1; load = 1'b0; en = 1'b0; din = 1'b0; clr_cnt = 1'b0;
        pat_in = 4'h0; mask_in = 4'h0;
        for (int i = 0; i < 3; i++) begin
            hist_m[i] = 32'd0; nseen_m[i] = 0; cnt_m[i] = 0;
        end

        do_rst();
        do_rst();
        check_val("rst_fill", {29'd0, fill_ov}, 32'd0);
        check_val("rst_cnt",  {24'd0, cnt_ov}, 32'd0);

        // Stream 1,0,1,1,0,1,1 with and without overlap.
        seq1 = 4'b1011;
        for (int i = 3; i >= 0; i--) bit_in(seq1[i]);
        check_val("first_det_ov",  {31'd0, det_ov},  32'd1);
        check_val("first_det_nov", {31'd0, det_nov}, 32'd1);
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        check_val("ov_end_det",  {31'd0, det_ov},  32'd1);
        check_val("ov_end_cnt",  {24'd0, cnt_ov},  32'd2);
        check_val("ov_end_fill", {29'd0, fill_ov}, 32'd4);
        check_val("nov_end_det",  {31'd0, det_nov},  32'd0);
        check_val("nov_end_cnt",  {24'd0, cnt_nov},  32'd1);
        check_val("nov_end_fill", {29'd0, fill_nov}, 32'd3);

        // Reset mid-sequence discards the partial history.
        do_rst();
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        do_rst();
        bit_in(1'b1);
        check_val("midrst_fill", {29'd0, fill_ov}, 32'd1);
        check_val("midrst_cnt",  {24'd0, cnt_ov},  32'd0);
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        check_val("midrst_pat_det", {31'd0, det_ov}, 32'd1);

        // Load 0110 with a qualified bit on the load cycle, then gapped bits.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0110, 4'b1111);
        check_val("load_fill", {29'd0, fill_ov}, 32'd0);
        bit_in(1'b0); idle(); bit_in(1'b1); idle(); idle(); bit_in(1'b1); idle();
        check_val("gap_fill", {29'd0, fill_ov}, 32'd3);
        bit_in(1'b0);
        check_val("load_det", {31'd0, det_ov}, 32'd1);
        idle();
        check_val("det_one_cycle", {31'd0, det_ov}, 32'd0);

        // Saturation: pattern 1111 and a run of ones.
        do_rst();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111);
        for (int i = 0; i < 11; i++) bit_in(1'b1);
        check_val("sat_cnt_max", {30'd0, cnt_sat}, 32'd3);
        check_val("sat_ov_cnt",  {24'd0, cnt_ov},  32'd8);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
        check_val("clr_with_match_sat", {30'd0, cnt_sat}, 32'd1);
        check_val("clr_with_match_ov",  {24'd0, cnt_ov},  32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        check_val("clr_no_match", {24'd0, cnt_ov}, 32'd0);

        // Masked compare: pattern 1011, mask 1101, stream 1001.
        do_rst();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 4'b1101);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b0); bit_in(1'b1);
        check_val("mask_det", {31'd0, det_ov}, {31'd0, EXP_MASK_DET});

        // Random traffic against the model.
        do_rst();
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
